// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state, flag indices and default widths for the ALU execute stage.
package alu_pkg;

  localparam int ALU_WIDTH   = 16;
  localparam int ALU_SHAMT_W = 4;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_CMP   = 4'b0101;
  localparam logic [3:0] ALU_MOV   = 4'b0110;
  localparam logic [3:0] ALU_NOP   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SLR   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_PASS0 = 4'b1100;
  localparam logic [3:0] ALU_PASS1 = 4'b1101;
  localparam logic [3:0] ALU_PASS2 = 4'b1110;
  localparam logic [3:0] ALU_PASS3 = 4'b1111;

  // Shift kind is the low two opcode bits of a shift op.
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SLR = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate of a WIDTH-bit word; o_out_bit is the bit leaving
// the word (for rotate, the bit wrapped into position 0).
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [1:0]       i_kind,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_out_bit
);

  always_comb begin
    o_dout    = i_din;
    o_out_bit = 1'b0;
    case (i_kind)
      SH_SLL: begin
        o_dout    = {i_din[WIDTH-2:0], 1'b0};
        o_out_bit = i_din[WIDTH-1];
      end
      SH_SLR: begin
        o_dout    = {i_din[WIDTH-2:0], i_din[WIDTH-1]};
        o_out_bit = i_din[WIDTH-1];
      end
      SH_SRL: begin
        o_dout    = {1'b0, i_din[WIDTH-1:1]};
        o_out_bit = i_din[0];
      end
      SH_SRA: begin
        o_dout    = {i_din[WIDTH-1], i_din[WIDTH-1:1]};
        o_out_bit = i_din[0];
      end
      default: begin
        o_dout    = i_din;
        o_out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle arithmetic/logic, iterative one-bit-per-cycle
// shifts with start/busy/done. Define ALU_BARREL_SHIFT_EN for 1-cycle shifts.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         ALU_Cnt,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_flags;
  logic                 r_done;
  logic [WIDTH-1:0]     r_sh_val;
  logic [1:0]           r_sh_kind;
  logic [SHAMT_W-1:0]   r_cnt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic                 w_add_v;
  logic                 w_sub_v;
  logic [WIDTH-1:0]     w_alu_res;
  logic [WIDTH-1:0]     w_fsrc;
  logic                 w_c;
  logic                 w_v;
  logic [3:0]           w_alu_flags;
  logic [WIDTH-1:0]     w_shift_res;
  logic                 w_shift_c;
  logic                 w_long;
  logic [WIDTH-1:0]     w_first_val;
  logic                 w_first_c;
  logic [WIDTH-1:0]     w_iter_val;
  logic                 w_iter_c;
  logic [3:0]           w_iter_flags;

  // First step is taken at the start edge, so an n-bit shift finishes n edges later.
  alu_shift_step #(.WIDTH(WIDTH)) u_step_first (
    .i_kind    (ALU_Cnt[1:0]),
    .i_din     (in_a),
    .o_dout    (w_first_val),
    .o_out_bit (w_first_c)
  );

  alu_shift_step #(.WIDTH(WIDTH)) u_step_iter (
    .i_kind    (r_sh_kind),
    .i_din     (r_sh_val),
    .o_dout    (w_iter_val),
    .o_out_bit (w_iter_c)
  );

`ifdef ALU_BARREL_SHIFT_EN
  localparam int MAX_SH = (1 << SHAMT_W) - 1;

  logic [WIDTH-1:0] w_stage   [0:MAX_SH];
  logic             w_stage_c [0:MAX_SH];

  assign w_stage[0]   = in_a;
  assign w_stage_c[0] = 1'b0;

  for (genvar gi = 0; gi < MAX_SH; gi++) begin : g_barrel
    alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .i_kind    (ALU_Cnt[1:0]),
      .i_din     (w_stage[gi]),
      .o_dout    (w_stage[gi+1]),
      .o_out_bit (w_stage_c[gi+1])
    );
  end

  assign w_shift_res = w_stage[shamt];
  assign w_shift_c   = w_stage_c[shamt];
  assign w_long      = 1'b0;
`else
  assign w_shift_res = (shamt == '0) ? in_a : w_first_val;
  assign w_shift_c   = (shamt == '0) ? 1'b0 : w_first_c;
  assign w_long      = is_shift_op(ALU_Cnt) && (shamt > CNT_ONE);
`endif

  assign w_sum   = {1'b0, in_a} + {1'b0, in_b};
  // Top bit of the widened difference is the unsigned borrow (A < B).
  assign w_diff  = {1'b0, in_a} - {1'b0, in_b};
  assign w_add_v = (in_a[MSB] == in_b[MSB]) && (w_sum[MSB] != in_a[MSB]);
  assign w_sub_v = (in_a[MSB] != in_b[MSB]) && (w_diff[MSB] != in_a[MSB]);

  always_comb begin
    w_alu_res = in_b;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (ALU_Cnt)
      ALU_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_c       = w_sum[WIDTH];
        w_v       = w_add_v;
      end
      ALU_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_c       = w_diff[WIDTH];
        w_v       = w_sub_v;
      end
      ALU_CMP: begin
        w_alu_res = in_a;
        w_c       = w_diff[WIDTH];
        w_v       = w_sub_v;
      end
      ALU_AND: w_alu_res = in_a & in_b;
      ALU_OR:  w_alu_res = in_a | in_b;
      ALU_XOR: w_alu_res = in_a ^ in_b;
      ALU_MOV: w_alu_res = in_b;
      ALU_NOP: w_alu_res = in_a;
      ALU_SLL, ALU_SLR, ALU_SRL, ALU_SRA: begin
        w_alu_res = w_shift_res;
        w_c       = w_shift_c;
      end
      default: w_alu_res = in_b;
    endcase
  end

  // CMP keeps A as its result but reports S/Z of the difference.
  assign w_fsrc = (ALU_Cnt == ALU_CMP) ? w_diff[WIDTH-1:0] : w_alu_res;

  always_comb begin
    w_alu_flags         = '0;
    w_alu_flags[FLAG_S] = w_fsrc[MSB];
    w_alu_flags[FLAG_Z] = (w_fsrc == '0);
    w_alu_flags[FLAG_C] = w_c;
    w_alu_flags[FLAG_V] = w_v;
  end

  always_comb begin
    w_iter_flags         = '0;
    w_iter_flags[FLAG_S] = w_iter_val[MSB];
    w_iter_flags[FLAG_Z] = (w_iter_val == '0);
    w_iter_flags[FLAG_C] = w_iter_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start && w_long) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_ONE) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_flags   <= '0;
      r_done    <= 1'b0;
      r_sh_val  <= '0;
      r_sh_kind <= SH_SLL;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_long) begin
              r_sh_val  <= w_first_val;
              r_sh_kind <= ALU_Cnt[1:0];
              r_cnt     <= shamt - CNT_ONE;
            end else begin
              r_result <= w_alu_res;
              r_flags  <= w_alu_flags;
              r_done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_sh_val <= w_iter_val;
          r_cnt    <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_result <= w_iter_val;
            r_flags  <= w_iter_flags;
            r_done   <= 1'b1;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, hand sequences for
// multi-cycle corners, and random ops against a plain-arithmetic model.
module tb_alu_exec_unit;
  import alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ALU_Cnt;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  n;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs [17];

  alu_exec_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ALU_Cnt (ALU_Cnt),
    .in_a    (in_a),
    .in_b    (in_b),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [3:0] n);
    if (op[3:2] == 2'b10 && n >= 4'd2 && !BARREL) return int'(n);
    return 1;
  endfunction

  // Returns {S,Z,C,V, result} from the operation's arithmetic definition.
  function automatic logic [19:0] ref_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] n);
    int ua, ub, sa, sb, sum, dif, ssum, sdif;
    logic [15:0] res, fsrc;
    logic [31:0] dbl;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sum = ua + ub;
    dif = ua - ub;
    ssum = sa + sb;
    sdif = sa - sb;
    c = 1'b0;
    v = 1'b0;
    res = b;
    case (op)
      ALU_ADD: begin
        res = 16'(sum);
        c = (sum > 65535);
        v = (ssum > 32767) || (ssum < -32768);
      end
      ALU_SUB, ALU_CMP: begin
        res = (op == ALU_CMP) ? a : 16'(dif);
        c = (ua < ub);
        v = (sdif > 32767) || (sdif < -32768);
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_MOV: res = b;
      ALU_NOP: res = a;
      ALU_SLL: begin
        res = a << n;
        if (n != 0) c = a[16 - int'(n)];
      end
      ALU_SLR: begin
        dbl = {a, a} << n;
        res = dbl[31:16];
        if (n != 0) c = res[0];
      end
      ALU_SRL: begin
        res = a >> n;
        if (n != 0) c = a[int'(n) - 1];
      end
      ALU_SRA: begin
        res = 16'($signed(a) >>> n);
        if (n != 0) c = a[int'(n) - 1];
      end
      default: res = b;
    endcase
    fsrc = (op == ALU_CMP) ? 16'(dif) : res;
    return {fsrc[15], (fsrc == 16'h0000), c, v, res};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] n, input logic [15:0] er, input logic [3:0] ef,
                        input bit scramble, input string tag);
    int lat, k, busy_bad;
    bit seen;
    lat = exp_lat(op, n);
    @(negedge clk);
    ALU_Cnt = op; in_a = a; in_b = b; shamt = n; start = 1'b1;
    seen = 1'b0; k = 0; busy_bad = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (busy !== (k < lat)) busy_bad++;
      if (done === 1'b1) seen = 1'b1;
      else if (scramble) begin
        ALU_Cnt = 4'($urandom); in_a = 16'($urandom); shamt = 4'($urandom);
      end
    end
    check({tag, " latency"}, seen ? k : 999, lat);
    check({tag, " result"}, result, er);
    check({tag, " flags"}, flags, ef);
    check({tag, " busy profile"}, busy_bad, 0);
    @(negedge clk);
    check({tag, " single done"}, done, 1'b0);
    $display("op=%h a=%h b=%h n=%0d -> result=%h flags=%b latency=%0d [%s]",
             op, a, b, n, result, flags, k, tag);
  endtask

  initial begin
    int k, lat, extra;
    bit seen;
    logic [3:0]  op, n;
    logic [15:0] a, b;
    logic [19:0] e;

    rst = 1'b1; start = 1'b0; ALU_Cnt = '0; in_a = '0; in_b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 16'h0000);
    check("reset flags", flags, 4'h0);
    rst = 1'b0;

    // {op, a, b, shamt, result, {S,Z,C,V}}
    vecs[0]  = '{ALU_ADD,   16'h7FFF, 16'h0001, 4'd0,  16'h8000, 4'b1001};
    vecs[1]  = '{ALU_SUB,   16'h0003, 16'h0005, 4'd0,  16'hFFFE, 4'b1010};
    vecs[2]  = '{ALU_CMP,   16'h0003, 16'h0005, 4'd0,  16'h0003, 4'b1010};
    vecs[3]  = '{ALU_SRA,   16'h8001, 16'h0000, 4'd3,  16'hF000, 4'b1000};
    vecs[4]  = '{ALU_XOR,   16'hFF00, 16'h0FF0, 4'd0,  16'hF0F0, 4'b1000};
    vecs[5]  = '{ALU_MOV,   16'h1234, 16'h0000, 4'd0,  16'h0000, 4'b0100};
    vecs[6]  = '{ALU_AND,   16'hF0F0, 16'h0F0F, 4'd0,  16'h0000, 4'b0100};
    vecs[7]  = '{ALU_OR,    16'hF000, 16'h000F, 4'd0,  16'hF00F, 4'b1000};
    vecs[8]  = '{ALU_NOP,   16'h1234, 16'hFFFF, 4'd0,  16'h1234, 4'b0000};
    vecs[9]  = '{ALU_PASS0, 16'h0000, 16'hABCD, 4'd0,  16'hABCD, 4'b1000};
    vecs[10] = '{ALU_SLL,   16'h8001, 16'h0000, 4'd1,  16'h0002, 4'b0010};
    vecs[11] = '{ALU_SRL,   16'h0003, 16'h0000, 4'd0,  16'h0003, 4'b0000};
    vecs[12] = '{ALU_ADD,   16'hFFFF, 16'h0001, 4'd0,  16'h0000, 4'b0110};
    vecs[13] = '{ALU_SUB,   16'h8000, 16'h0001, 4'd0,  16'h7FFF, 4'b0001};
    vecs[14] = '{ALU_SLL,   16'h0001, 16'h0000, 4'd15, 16'h8000, 4'b1000};
    vecs[15] = '{ALU_SRL,   16'hFFFF, 16'h0000, 4'd4,  16'h0FFF, 4'b0010};
    vecs[16] = '{ALU_PASS3, 16'h5555, 16'h0000, 4'd0,  16'h0000, 4'b0100};

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].res, vecs[i].fl,
             1'b0, $sformatf("vec%0d", i));
    end

    // SLR by 15 with a second start injected mid-shift, which must be ignored.
    @(negedge clk);
    ALU_Cnt = ALU_SLR; in_a = 16'h8001; in_b = 16'h0000; shamt = 4'd15; start = 1'b1;
    lat = exp_lat(ALU_SLR, 4'd15);
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else if (k == 4) begin
        ALU_Cnt = ALU_ADD; in_a = 16'h0001; in_b = 16'h0001; shamt = 4'd0; start = 1'b1;
      end
    end
    check("slr15 latency", seen ? k : 999, lat);
    check("slr15 result", result, 16'hC000);
    check("slr15 flags", flags, 4'b1000);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("slr15 ignored start", extra, 0);
    $display("SLR 8001 by 15 -> result=%h flags=%b latency=%0d", result, flags, k);

    // Reset during the second cycle of an 8-bit SLL.
    @(negedge clk);
    ALU_Cnt = ALU_SLL; in_a = 16'h00FF; in_b = 16'h0000; shamt = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort result", result, 16'h0000);
    check("abort flags", flags, 4'h0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("abort no done", extra, 0);
    $display("SLL aborted by rst -> result=%h flags=%b busy=%b", result, flags, busy);
    run_op(ALU_ADD, 16'h1111, 16'h2222, 4'd0, 16'h3333, 4'b0000, 1'b0, "add after rst");

    // Back-to-back: MOV started in the cycle XOR reports done.
    @(negedge clk);
    ALU_Cnt = ALU_XOR; in_a = 16'hFF00; in_b = 16'h0FF0; shamt = 4'd0; start = 1'b1;
    @(negedge clk);
    check("b2b xor done", done, 1'b1);
    check("b2b xor result", result, 16'hF0F0);
    check("b2b xor flags", flags, 4'b1000);
    ALU_Cnt = ALU_MOV; in_b = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    check("b2b mov done", done, 1'b1);
    check("b2b mov result", result, 16'h0000);
    check("b2b mov flags", flags, 4'b0100);
    @(negedge clk);
    check("b2b done drops", done, 1'b0);
    $display("back-to-back XOR then MOV -> result=%h flags=%b", result, flags);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      n  = (i % 4 == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      if (i % 5 == 0) b = a;
      e  = ref_model(op, a, b, n);
      run_op(op, a, b, n, e[15:0], e[19:16], (i % 2 == 1), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
